profile_bus_monitor: RTL

Bus-activity monitor that sits directly upstream of the profiling custom instruction. It tracks bus arbitration and transactions with a small state machine and produces the registered `busIdle` level that the profiler's bus-idle counter integrates. It also emits per-transaction beat statistics and a protocol-error indication for debug.

---
 rtl/profile_bus_pkg.sv | 19 +
 rtl/profile_bus_watchdog.sv | 28 ++
 rtl/profile_bus_monitor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/profile_bus_pkg.sv
// Shared types and constants for the profiling bus-activity monitor.
package profile_bus_pkg;

  localparam int unsigned BEAT_W   = 9;
  localparam int unsigned BEAT_MAX = 511;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARBITRATE,
    ST_GRANTED,
    ST_TRANSFER
  } bus_state_e;

  function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] count,
                                                 input logic            beat);
    return (beat && count != BEAT_W'(BEAT_MAX)) ? count + 1'b1 : count;
  endfunction

endpackage

// File: rtl/profile_bus_watchdog.sv
// Silent-cycle counter for the TRANSFER state; flags an abort on the limit-th silent cycle.
module profile_bus_watchdog #(
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(WATCHDOG_CYCLES - 1);

  logic [15:0] cnt;

  assign timeout = tick && !clear && (cnt == LIMIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/profile_bus_monitor.sv
// Bus arbitration/transaction monitor producing the profiler's busIdle level and beat stats.
// Optional TRANSFER watchdog enabled by defining PROFILE_BUS_WATCHDOG_EN.
module profile_bus_monitor
  import profile_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 8,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] busRequests,
  input  logic [NUM_MASTERS-1:0] busGrants,
  input  logic                   beginTransaction,
  input  logic                   endTransaction,
  input  logic                   dataValid,
  input  logic                   busError,
  input  logic [7:0]             burstSize,
  output logic                   busIdle,
  output logic                   arbitrationWait,
  output logic                   transactionDone,
  output logic [BEAT_W-1:0]      lastBeatCount,
  output logic                   beatMismatch,
  output logic                   errorSeen,
  output logic                   watchdogTimeout
);

  bus_state_e        state, state_d;
  logic [BEAT_W-1:0] beat_count, beat_d, expected, exp_d, last_d;
  logic [BEAT_W-1:0] beats_next, expected_new, dv_beats;
  logic              done_d, mism_d, err_d, wd_d, single_d;
  logic              any_req, any_gnt, terminate, wd_timeout;
  bus_state_e        exit_state;

`ifdef PROFILE_BUS_WATCHDOG_EN
  logic wd_clear, wd_tick;
  assign wd_tick  = (state == ST_TRANSFER);
  assign wd_clear = beginTransaction | dataValid | (state != ST_TRANSFER);

  profile_bus_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .tick   (wd_tick),
    .timeout(wd_timeout)
  );
`else
  assign wd_timeout = 1'b0;
`endif

  assign any_req      = |busRequests;
  assign any_gnt      = |busGrants;
  assign terminate    = endTransaction | busError;
  assign exit_state   = any_req ? ST_ARBITRATE : ST_IDLE;
  assign beats_next   = beat_inc(beat_count, dataValid);
  assign expected_new = BEAT_W'(burstSize) + 1'b1;
  assign dv_beats     = {{(BEAT_W-1){1'b0}}, dataValid};

  always_comb begin
    state_d  = state;
    beat_d   = beat_count;
    exp_d    = expected;
    last_d   = lastBeatCount;
    done_d   = 1'b0;
    mism_d   = 1'b0;
    wd_d     = 1'b0;
    single_d = 1'b0;
    err_d    = errorSeen | busError;
    if (state == ST_TRANSFER) begin
      if (terminate) begin
        state_d = exit_state;
        beat_d  = beats_next;
        last_d  = beats_next;
        done_d  = 1'b1;
        mism_d  = (beats_next != expected);
      end else if (beginTransaction) begin
        exp_d  = expected_new;
        beat_d = dv_beats;
        err_d  = 1'b1;
      end else if (wd_timeout) begin
        state_d = ST_IDLE;
        wd_d    = 1'b1;
        err_d   = 1'b1;
      end else begin
        beat_d = beats_next;
      end
    end else if (beginTransaction) begin
      exp_d  = expected_new;
      beat_d = dv_beats;
      if (terminate) begin
        // Single-cycle transaction: never enters TRANSFER, busIdle held low for its done cycle.
        single_d = 1'b1;
        state_d  = exit_state;
        last_d   = dv_beats;
        done_d   = 1'b1;
        mism_d   = (dv_beats != expected_new);
      end else begin
        state_d = ST_TRANSFER;
      end
    end else begin
      unique case (state)
        ST_IDLE:      if (any_gnt) state_d = ST_GRANTED;
                      else if (any_req) state_d = ST_ARBITRATE;
        ST_ARBITRATE: if (any_gnt) state_d = ST_GRANTED;
                      else if (!any_req) state_d = ST_IDLE;
        ST_GRANTED:   if (!any_gnt) state_d = exit_state;
        default:      state_d = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      beat_count      <= '0;
      expected        <= '0;
      busIdle         <= 1'b1;
      arbitrationWait <= 1'b0;
      transactionDone <= 1'b0;
      lastBeatCount   <= '0;
      beatMismatch    <= 1'b0;
      errorSeen       <= 1'b0;
      watchdogTimeout <= 1'b0;
    end else begin
      state           <= state_d;
      beat_count      <= beat_d;
      expected        <= exp_d;
      busIdle         <= (state_d == ST_IDLE) && !single_d;
      arbitrationWait <= (state_d == ST_ARBITRATE);
      transactionDone <= done_d;
      lastBeatCount   <= last_d;
      beatMismatch    <= mism_d;
      errorSeen       <= err_d;
      watchdogTimeout <= wd_d;
    end
  end

endmodule
